// File: rtl/xif_tracker_pkg.sv
// rtl/xif_tracker_pkg.sv - shared types and error indices for the CV-X-IF issue tracker
package xif_tracker_pkg;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2
  } entry_state_e;

  localparam int NUM_ERR      = 5;
  localparam int ERR_UNSTABLE = 0;
  localparam int ERR_BUSY     = 1;
  localparam int ERR_COMMIT   = 2;
  localparam int ERR_RESULT   = 3;
  localparam int ERR_DROP     = 4;

endpackage

// File: rtl/xif_sat_counter.sv
// rtl/xif_sat_counter.sv - saturating up-counter with synchronous clear
module xif_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/xif_issue_tracker.sv
// rtl/xif_issue_tracker.sv - passive CV-X-IF monitor: per-ID scoreboard, statistics,
// issue-to-result latency and sticky protocol error flags
module xif_issue_tracker
  import xif_tracker_pkg::*;
#(
  parameter int X_ID_WIDTH    = 4,
  parameter int X_INSTR_WIDTH = 32,
  parameter int CNT_WIDTH     = 32,
  parameter int CHECK_STABLE  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic                     issue_ready_i,
  input  logic [X_INSTR_WIDTH-1:0] issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic                     issue_accept_i,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  input  logic                     result_valid_i,
  input  logic                     result_ready_i,
  input  logic [X_ID_WIDTH-1:0]    result_id_i,
  input  logic                     clear_i,
  output logic [CNT_WIDTH-1:0]     cnt_issued_o,
  output logic [CNT_WIDTH-1:0]     cnt_rejected_o,
  output logic [CNT_WIDTH-1:0]     cnt_killed_o,
  output logic [CNT_WIDTH-1:0]     cnt_retired_o,
  output logic [X_ID_WIDTH:0]      outstanding_o,
  output logic [CNT_WIDTH-1:0]     lat_last_o,
  output logic [CNT_WIDTH-1:0]     lat_max_o,
  output logic [NUM_ERR-1:0]       err_o,
  output logic [X_ID_WIDTH-1:0]    err_first_id_o
);

  localparam int NUM_IDS = 2 ** X_ID_WIDTH;

  entry_state_e             state_q [NUM_IDS];
  entry_state_e             state_d [NUM_IDS];
  logic [CNT_WIDTH-1:0]     start_q [NUM_IDS];
  logic [CNT_WIDTH-1:0]     start_d [NUM_IDS];
  logic [CNT_WIDTH-1:0]     ts_q, ts_d;
  logic [CNT_WIDTH-1:0]     lat_last_q, lat_last_d, lat_max_q, lat_max_d;
  logic [NUM_ERR-1:0]       err_q, err_d;
  logic [X_ID_WIDTH-1:0]    err_first_id_q, err_first_id_d;
  logic [X_ID_WIDTH:0]      outstanding_q, outstanding_d;
  logic                     hold_valid_q, hold_valid_d;
  logic [X_INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [X_ID_WIDTH-1:0]    hold_id_q, hold_id_d;

  logic                     inc_issued, inc_rejected, inc_killed, inc_retired;
  logic [NUM_ERR-1:0]       err_set;
  logic [X_ID_WIDTH-1:0]    err_id [NUM_ERR];
  logic [CNT_WIDTH-1:0]     lat;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    err_set      = '0;
    for (int i = 0; i < NUM_ERR; i++) err_id[i] = '0;
    inc_issued   = 1'b0;
    inc_rejected = 1'b0;
    inc_killed   = 1'b0;
    inc_retired  = 1'b0;
    lat          = '0;
    ts_d         = ts_q + CNT_WIDTH'(1);

    // Result is evaluated against the pre-commit state, then commit, then issue.
    if (result_valid_i && result_ready_i) begin
      if (state_q[result_id_i] == COMMITTED) begin
        state_d[result_id_i] = FREE;
        inc_retired          = 1'b1;
        lat                  = ts_q - start_q[result_id_i];
      end else begin
        err_set[ERR_RESULT] = 1'b1;
        err_id[ERR_RESULT]  = result_id_i;
      end
    end

    if (commit_valid_i) begin
      if (state_d[commit_id_i] == ISSUED) begin
        state_d[commit_id_i] = commit_kill_i ? FREE : COMMITTED;
        inc_killed           = commit_kill_i;
      end else begin
        err_set[ERR_COMMIT] = 1'b1;
        err_id[ERR_COMMIT]  = commit_id_i;
      end
    end

    if (issue_valid_i && issue_ready_i) begin
      if (issue_accept_i) begin
        inc_issued          = 1'b1;
        start_d[issue_id_i] = ts_q;
        if (state_d[issue_id_i] == FREE) begin
          state_d[issue_id_i] = ISSUED;
        end else begin
          err_set[ERR_BUSY] = 1'b1;
          err_id[ERR_BUSY]  = issue_id_i;
        end
      end else begin
        inc_rejected = 1'b1;
      end
    end

    hold_valid_d = issue_valid_i && !issue_ready_i;
    hold_instr_d = issue_instr_i;
    hold_id_d    = issue_id_i;
    if (CHECK_STABLE != 0) begin
      if (hold_valid_q && issue_valid_i &&
          ((issue_instr_i != hold_instr_q) || (issue_id_i != hold_id_q))) begin
        err_set[ERR_UNSTABLE] = 1'b1;
        err_id[ERR_UNSTABLE]  = issue_id_i;
      end
      if (hold_valid_q && !issue_valid_i) begin
        err_set[ERR_DROP] = 1'b1;
        err_id[ERR_DROP]  = hold_id_q;
      end
    end

    outstanding_d = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (state_d[i] != FREE) outstanding_d = outstanding_d + (X_ID_WIDTH + 1)'(1);
    end

    err_d          = err_q | err_set;
    err_first_id_d = err_first_id_q;
    if ((err_q == '0) && (err_set != '0)) begin
      for (int i = NUM_ERR - 1; i >= 0; i--) begin
        if (err_set[i]) err_first_id_d = err_id[i];
      end
    end

    lat_last_d = lat_last_q;
    lat_max_d  = lat_max_q;
    if (inc_retired) begin
      lat_last_d = lat;
      if (lat > lat_max_q) lat_max_d = lat;
    end

    if (clear_i) begin
      err_d          = '0;
      err_first_id_d = '0;
      lat_last_d     = '0;
      lat_max_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        state_q[i] <= FREE;
        start_q[i] <= '0;
      end
      ts_q           <= '0;
      lat_last_q     <= '0;
      lat_max_q      <= '0;
      err_q          <= '0;
      err_first_id_q <= '0;
      outstanding_q  <= '0;
      hold_valid_q   <= 1'b0;
      hold_instr_q   <= '0;
      hold_id_q      <= '0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      ts_q           <= ts_d;
      lat_last_q     <= lat_last_d;
      lat_max_q      <= lat_max_d;
      err_q          <= err_d;
      err_first_id_q <= err_first_id_d;
      outstanding_q  <= outstanding_d;
      hold_valid_q   <= hold_valid_d;
      hold_instr_q   <= hold_instr_d;
      hold_id_q      <= hold_id_d;
    end
  end

  xif_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_issued (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(inc_issued), .clr_i(clear_i), .count_o(cnt_issued_o)
  );
  xif_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_rejected (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(inc_rejected), .clr_i(clear_i), .count_o(cnt_rejected_o)
  );
  xif_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_killed (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(inc_killed), .clr_i(clear_i), .count_o(cnt_killed_o)
  );
  xif_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_retired (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(inc_retired), .clr_i(clear_i), .count_o(cnt_retired_o)
  );

  assign outstanding_o  = outstanding_q;
  assign lat_last_o     = lat_last_q;
  assign lat_max_o      = lat_max_q;
  assign err_o          = err_q;
  assign err_first_id_o = err_first_id_q;

endmodule

// File: doc/xif_issue_tracker.md
Name: xif_issue_tracker

Overview:
Passive, synthesizable monitor for the CV-X-IF offload path between the CPU and the TCA coprocessor. It tracks every offloaded instruction by ID through issue, commit and result. It also:
- keeps saturating statistics counters;
- measures issue-to-result latency;
- flags protocol violations on sticky error outputs.
It sits in the tca_system testbench and FPGA debug builds, beside the interface, and never drives it.

Parameters:
X_ID_WIDTH, 4, width of instruction ID; the scoreboard has 2**X_ID_WIDTH entries
X_INSTR_WIDTH, 32, width of the offloaded instruction word
CNT_WIDTH, 32, width of every statistics counter and the timestamp
CHECK_STABLE, 1, 1 enables the issue-request stability check

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  issue request valid
issue_ready_i  in  1  issue request ready
issue_instr_i  in  X_INSTR_WIDTH  issued instruction
issue_id_i  in  X_ID_WIDTH  issued ID
issue_accept_i  in  1  coprocessor accepted the offload (qualified by handshake)
commit_valid_i  in  1  commit valid
commit_id_i  in  X_ID_WIDTH  committed ID
commit_kill_i  in  1  commit kills the instruction
result_valid_i  in  1  result valid
result_ready_i  in  1  result ready
result_id_i  in  X_ID_WIDTH  result ID
clear_i  in  1  synchronous clear of counters, latency and errors (scoreboard untouched)
cnt_issued_o  out  CNT_WIDTH  accepted issue handshakes
cnt_rejected_o  out  CNT_WIDTH  issue handshakes with accept=0
cnt_killed_o  out  CNT_WIDTH  commits with kill=1 on an ISSUED ID
cnt_retired_o  out  CNT_WIDTH  result handshakes on a COMMITTED ID
outstanding_o  out  X_ID_WIDTH+1  number of non-FREE entries
lat_last_o  out  CNT_WIDTH  latency of the most recent retirement
lat_max_o  out  CNT_WIDTH  maximum retirement latency
err_o  out  5  sticky flags: [0] unstable issue, [1] issue to busy ID, [2] commit to non-ISSUED ID, [3] result to non-COMMITTED ID, [4] valid dropped without ready
err_first_id_o  out  X_ID_WIDTH  ID involved in the first error after reset or clear

Behaviour:
- Reset, asynchronous, rst_ni=0:
  - all outputs 0;
  - every scoreboard entry FREE;
  - free-running timestamp 0.
- Timestamp: increments every cycle and wraps modulo 2**CNT_WIDTH.
- Latency: the timestamp difference, wrap-safe by modular subtraction.
- Per-ID state machine, states FREE / ISSUED / COMMITTED:
  - FREE -> ISSUED on issue handshake (valid & ready) with accept=1; latch the timestamp for that ID.
  - ISSUED -> FREE on commit_valid with kill=1.
  - ISSUED -> COMMITTED on commit_valid with kill=0.
  - COMMITTED -> FREE on result handshake (valid & ready); lat_last_o <= latency; lat_max_o <= max(lat_max_o, latency).
  - Illegal events set the matching err bit and leave the entry state unchanged, except that an issue to a busy ID restarts its timestamp.
- Issue handshake with accept=0: cnt_rejected_o++, no scoreboard change.
- Same-cycle events, processed in the order result, then commit, then issue:
  - A result freeing ID n and an issue to ID n in the same cycle is legal; the entry ends ISSUED.
  - A commit and a result on the same ID in the same cycle: the result sees the pre-commit state and flags err[3] if that state was not COMMITTED.
- Stability check (CHECK_STABLE=1): a registered copy of instr/id is held while valid=1 and ready=0.
  - The next cycle with valid=1 and differing instr or id sets err[0].
  - valid falling to 0 while the previous cycle had valid=1 and ready=0 sets err[4].
- Counters: all saturate at all-ones; they do not wrap.
- outstanding_o: updated the same cycle as the state changes, i.e. it is a registered count of entries.
- Errors and err_first_id_o:
  - err_o bits are sticky until clear_i or reset.
  - err_first_id_o is captured only when err_o was all-zero before the cycle.
  - If several errors fire in that first cycle, the lowest err bit index wins.
- clear_i: outputs read 0 the cycle after clear_i=1. If clear_i coincides with events, clear wins for counters and errors; the scoreboard still updates.
- Latency: 1 cycle from the triggering event to every registered output.

Decomposition:
- Package xif_tracker_pkg holds:
  - entry_state_e (FREE, ISSUED, COMMITTED);
  - err_idx constants ERR_UNSTABLE..ERR_DROP;
  - localparam NUM_ERR=5.
- One sub-module, xif_sat_counter: parametrised width, with inc and clr inputs. It is instantiated four times.

Test Plan:
1. Issue id=3 accept=1 at t=10, commit id=3 kill=0 at t=12, result handshake id=3 at t=17:
   - cnt_issued_o=1 and cnt_retired_o=1;
   - lat_last_o=7 and lat_max_o=7;
   - outstanding_o goes 0->1->0;
   - err_o=0.
2. Issue id=2, then commit id=2 kill=1 -> cnt_killed_o=1, entry FREE, and a subsequent result id=2 sets err_o[3] with err_first_id_o=2.
3. Hold valid=1, ready=0 for 3 cycles and change instr from 0x0000_000B to 0x0000_100B in cycle 2 -> err_o[0]=1; with CHECK_STABLE=0 -> err_o=0.
4. Issue all 16 IDs without retirement (outstanding_o=16), then issue id=5 -> err_o[1]=1. Retire id=5 and issue id=5 in the same cycle -> no new error, outstanding_o stays 16.
5. Force cnt_issued_o near saturation (CNT_WIDTH=4, 17 issues) -> reads 15. clear_i pulse -> 0 next cycle, with outstanding_o unchanged.
6. Assert rst_ni=0 mid-transaction (2 outstanding, err_o[2] set) -> all outputs 0 immediately. After release, a result id=0 sets err_o[3].
